crc_stream_engine: RTL

Parametrised serial/parallel CRC generator and checker with valid/ready streaming on both sides; the successor to the fixed CRC-7 bit-serial engine.
- Generate mode: passes a frame through, then appends its CRC.
- Check mode: passes data through, consumes the trailing CRC and flags a mismatch.
- Sits between the command/data framer and the line serialiser of the SD-style host path.

---
 rtl/crc_stream_pkg.sv | 43 ++++
 rtl/crc_stream_lfsr.sv | 38 +++
 rtl/crc_stream_engine.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/crc_stream_pkg.sv
// Shared types and helpers for the streaming CRC engine.
package crc_stream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StAppend,
    StRecv
  } crc_state_e;

  // Advance the CRC by din_w data bits, MSB first. Widths up to 32 bits.
  function automatic logic [31:0] crc_step(input logic [31:0]  crc,
                                           input logic [31:0]  data,
                                           input logic [31:0]  poly,
                                           input int unsigned  crc_w,
                                           input int unsigned  din_w);
    logic [31:0] c;
    logic [31:0] mask;
    logic [31:0] top;
    logic [31:0] bit_sh;
    logic        fb;
    // For crc_w == 32 the shift yields 0 and the subtraction wraps to all ones.
    mask = (32'd1 << crc_w) - 32'd1;
    c    = crc & mask;
    for (int i = 31; i >= 0; i--) begin
      if (i < int'(din_w)) begin
        top    = c >> (crc_w - 1);
        bit_sh = data >> i;
        fb     = bit_sh[0] ^ top[0];
        c      = ((c << 1) ^ (fb ? poly : 32'd0)) & mask;
      end
    end
    return c;
  endfunction

  // Beats needed to carry the appended CRC (plus optional end bit).
  function automatic int unsigned num_app_beats(input int unsigned crc_w,
                                                input int unsigned din_w,
                                                input int unsigned end_bit);
    return (crc_w + end_bit + din_w - 1) / din_w;
  endfunction

endpackage

// File: rtl/crc_stream_lfsr.sv
// CRC register with per-beat parallel update; load restarts from INIT.
module crc_stream_lfsr
  import crc_stream_pkg::*;
#(
  parameter int unsigned      CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY  = 7'h09,
  parameter logic [CRC_W-1:0] INIT  = '0,
  parameter int unsigned      DIN_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIN_W-1:0] data_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q, crc_d, crc_base;

  always_comb begin
    crc_base = load_i ? INIT : crc_q;
    crc_d    = crc_base;
    if (en_i) begin
      crc_d = CRC_W'(crc_step(32'(crc_base), 32'(data_i), 32'(POLY), CRC_W, DIN_W));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator (appends CRC) / checker (consumes and compares CRC).
// Build option: CRC_STREAM_END_BIT_EN adds a constant '1' end bit after the CRC.
module crc_stream_engine
  import crc_stream_pkg::*;
#(
  parameter int unsigned      CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY  = 7'h09,
  parameter logic [CRC_W-1:0] INIT  = '0,
  parameter int unsigned      DIN_W = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [DIN_W-1:0] IN_DATA,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [DIN_W-1:0] OUT_DATA,
  output logic             OUT_LAST,
  output logic [CRC_W-1:0] CRC,
  output logic             CRC_DONE,
  output logic             CRC_ERR
);

`ifdef CRC_STREAM_END_BIT_EN
  localparam int unsigned END_BIT = 1;
`else
  localparam int unsigned END_BIT = 0;
`endif
  localparam int unsigned      APP_BITS = CRC_W + END_BIT;
  localparam int unsigned      NB       = num_app_beats(CRC_W, DIN_W, END_BIT);
  localparam int unsigned      PAD_W    = NB * DIN_W;
  localparam int unsigned      CNT_W    = $clog2(NB + 1);
  localparam logic [CNT_W-1:0] NB_C     = CNT_W'(NB);
  localparam logic [CNT_W-1:0] NB_M1    = CNT_W'(NB - 1);

  logic                rdy_en_q;
  crc_state_e          state_q, state_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PAD_W-1:0]    rx_q, rx_d, rx_shift;
  logic                out_valid_q, out_valid_d;
  logic [DIN_W-1:0]    out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                crc_done_q, crc_done_d;
  logic                crc_err_q, crc_err_d;
  logic                lfsr_load, lfsr_en;
  logic                frame_mode;
  logic                rx_bad;
  logic                out_free;
  logic                in_ready;
  logic                in_fire;
  logic [APP_BITS-1:0] app_bits;
  logic [PAD_W-1:0]    app_pad;
  int unsigned         app_shamt;
  logic [CRC_W-1:0]    crc;

  crc_stream_lfsr #(
    .CRC_W(CRC_W),
    .POLY (POLY),
    .INIT (INIT),
    .DIN_W(DIN_W)
  ) u_lfsr (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .load_i(lfsr_load),
    .en_i  (lfsr_en),
    .data_i(IN_DATA),
    .crc_o (crc)
  );

  // rdy_en_q keeps IN_READY low through reset and the first cycle after release.
  assign out_free = ~out_valid_q | OUT_READY;
  assign in_ready = rdy_en_q & out_free &
                    ((state_q == StIdle) | (state_q == StData) | (state_q == StRecv));
  assign in_fire  = IN_VALID & in_ready;

`ifdef CRC_STREAM_END_BIT_EN
  assign app_bits = {crc, 1'b1};
`else
  assign app_bits = crc;
`endif

  always_comb begin
    // Trailer left-aligned in NB beats, zero-padded in the final beat's LSBs.
    app_pad   = PAD_W'(app_bits) << (PAD_W - APP_BITS);
    app_shamt = 32'(NB_M1 - cnt_q) * DIN_W;
    rx_shift  = (rx_q << DIN_W) | PAD_W'(IN_DATA);
    rx_bad    = rx_shift[PAD_W-1 -: CRC_W] != crc;
`ifdef CRC_STREAM_END_BIT_EN
    rx_bad    = rx_bad | ~rx_shift[PAD_W-1-CRC_W];
`endif
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    out_valid_d = out_valid_q & ~OUT_READY;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    crc_done_d  = 1'b0;
    crc_err_d   = crc_err_q;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;
    frame_mode  = (state_q == StIdle) ? MODE : mode_q;

    unique case (state_q)
      StIdle, StData: begin
        if (in_fire) begin
          lfsr_load   = (state_q == StIdle);
          lfsr_en     = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = IN_DATA;
          out_last_d  = frame_mode & IN_LAST;
          if (state_q == StIdle) begin
            mode_d    = MODE;
            crc_err_d = 1'b0;
            state_d   = StData;
          end
          if (IN_LAST) begin
            cnt_d   = '0;
            state_d = frame_mode ? StRecv : StAppend;
          end
        end
      end
      StAppend: begin
        if (cnt_q != NB_C) begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = DIN_W'(app_pad >> app_shamt);
            out_last_d  = (cnt_q == NB_M1);
            cnt_d       = cnt_q + 1'b1;
          end
        end else if (out_valid_q && OUT_READY && out_last_q) begin
          // Only the final trailer beat can carry OUT_LAST in this state.
          crc_done_d = 1'b1;
          state_d    = StIdle;
        end
      end
      StRecv: begin
        if (in_fire) begin
          rx_d  = rx_shift;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == NB_M1) begin
            crc_err_d  = rx_bad;
            crc_done_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_en_q    <= 1'b0;
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      rx_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      crc_done_q  <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      rdy_en_q    <= 1'b1;
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      crc_done_q  <= crc_done_d;
      crc_err_q   <= crc_err_d;
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_LAST  = out_last_q;
  assign CRC       = crc;
  assign CRC_DONE  = crc_done_q;
  assign CRC_ERR   = crc_err_q;

endmodule
